alu_req_sched: RTL and testbench

- Two-requester scheduler that shares one ALU instance between two independent clients.
- Accepts a request from each client over a valid/ready handshake and arbitrates round-robin between them.
- Drives the ALU input bus, waits the command-dependent result latency, then captures the result and flags and returns them with a requester ID.
- Sits between client logic and the ALU, and owns the ALU input-side signals CE, INP_VALID, CMD, MODE, CIN, OPA and OPB.

---
 rtl/alu_sched_pkg.sv | 36 +++
 rtl/alu_rr_arb.sv | 43 ++++
 rtl/alu_req_sched.sv | 176 +++++++++++++++++
 tb/tb_alu_req_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-client ALU scheduler.
// Imported by the arbiter and the scheduler top.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int FLG_ERR   = 5;
  localparam int FLG_OFLOW = 4;
  localparam int FLG_COUT  = 3;
  localparam int FLG_G     = 2;
  localparam int FLG_L     = 1;
  localparam int FLG_E     = 0;
  localparam int NFLAGS    = FLG_ERR + 1;

  localparam int CMD_MUL_INC = 9;
  localparam int CMD_MUL_SHL = 10;

  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_BOTH = 2'b11;

  localparam int CNT_W = 8;

  function automatic logic is_mul(
    input logic mode,
    input int   cmd
  );
    return mode &&
      (cmd == CMD_MUL_INC ||
       cmd == CMD_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter.
// o_last is the requester granted most recently.
module alu_rr_arb
  import alu_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  input  logic       i_upd,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  logic       r_last;
  logic [1:0] w_gnt;

  // single valid wins; on a tie the one not granted last wins
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      unique case (i_valid)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // last-grant pointer; reset value makes requester 0 favoured
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_upd) begin
      r_last <= w_gnt[1];
    end
  end

  assign o_gnt  = w_gnt;
  assign o_last = r_last;

endmodule

// File: rtl/alu_req_sched.sv
// Shares one ALU between two valid/ready clients.
// Issues one op, waits its latency, returns tagged result.
module alu_req_sched
  import alu_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [M-1:0]      REQ0_CMD,
  input  logic              REQ0_MODE,
  input  logic              REQ0_CIN,
  input  logic [N-1:0]      REQ0_OPA,
  input  logic [N-1:0]      REQ0_OPB,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [M-1:0]      REQ1_CMD,
  input  logic              REQ1_MODE,
  input  logic              REQ1_CIN,
  input  logic [N-1:0]      REQ1_OPA,
  input  logic [N-1:0]      REQ1_OPB,
  output logic              ALU_CE,
  output logic [1:0]        ALU_INP_VALID,
  output logic [M-1:0]      ALU_CMD,
  output logic              ALU_MODE,
  output logic              ALU_CIN,
  output logic [N-1:0]      ALU_OPA,
  output logic [N-1:0]      ALU_OPB,
  input  logic [N:0]        ALU_RES,
  input  logic [NFLAGS-1:0] ALU_FLAGS,
  output logic              RSP_VALID,
  output logic              RSP_ID,
  output logic [N:0]        RSP_RES,
  output logic [NFLAGS-1:0] RSP_FLAGS
);

  state_e            r_state;
  state_e            w_next;
  logic [1:0]        w_valid;
  logic [1:0]        w_gnt;
  logic              w_last;
  logic              w_hs;
  logic              w_idle;
  logic              w_cap;
  logic [CNT_W-1:0]  r_cnt;
  logic [M-1:0]      r_cmd;
  logic              r_mode;
  logic              r_cin;
  logic [N-1:0]      r_opa;
  logic [N-1:0]      r_opb;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [N:0]        r_rsp_res;
  logic [NFLAGS-1:0] r_rsp_flags;

  assign w_valid = {REQ1_VALID, REQ0_VALID};
  assign w_idle  = (r_state == IDLE);
  assign w_hs    = |w_gnt;
  assign w_cap   = (r_state == WAIT) &&
                   (r_cnt == CNT_W'(1));

  alu_rr_arb u_arb (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_valid (w_valid),
    .i_en    (w_idle),
    .i_upd   (w_hs),
    .o_gnt   (w_gnt),
    .o_last  (w_last)
  );

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state: accept, issue for one cycle, wait out latency
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_cap) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: ready only while idle, ALU enabled while busy
  always_comb begin
    REQ0_READY    = w_gnt[0];
    REQ1_READY    = w_gnt[1];
    ALU_CE        = 1'b0;
    ALU_INP_VALID = IV_NONE;
    if (!w_idle) begin
      ALU_CE        = 1'b1;
      ALU_INP_VALID = IV_BOTH;
    end
  end

  // latch the granted payload; it stays on the ALU bus afterwards
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cmd  <= '0;
      r_mode <= 1'b0;
      r_cin  <= 1'b0;
      r_opa  <= '0;
      r_opb  <= '0;
    end else if (w_hs) begin
      if (w_gnt[1]) begin
        r_cmd  <= REQ1_CMD;
        r_mode <= REQ1_MODE;
        r_cin  <= REQ1_CIN;
        r_opa  <= REQ1_OPA;
        r_opb  <= REQ1_OPB;
      end else begin
        r_cmd  <= REQ0_CMD;
        r_mode <= REQ0_MODE;
        r_cin  <= REQ0_CIN;
        r_opa  <= REQ0_OPA;
        r_opb  <= REQ0_OPB;
      end
    end
  end

  // latency counter: loaded on issue, counts down while waiting
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      if (is_mul(r_mode, int'(r_cmd))) begin
        r_cnt <= CNT_W'(MUL_LAT);
      end else begin
        r_cnt <= CNT_W'(LAT);
      end
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // capture result; the grant pointer still names the owner here
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_flags <= '0;
    end else begin
      r_rsp_valid <= w_cap;
      if (w_cap) begin
        r_rsp_id    <= w_last;
        r_rsp_res   <= ALU_RES;
        r_rsp_flags <= ALU_FLAGS;
      end
    end
  end

  assign ALU_CMD   = r_cmd;
  assign ALU_MODE  = r_mode;
  assign ALU_CIN   = r_cin;
  assign ALU_OPA   = r_opa;
  assign ALU_OPB   = r_opb;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_rsp_id;
  assign RSP_RES   = r_rsp_res;
  assign RSP_FLAGS = r_rsp_flags;

endmodule

// File: tb/tb_alu_req_sched.sv
// Scoreboard bench for alu_req_sched with a behavioural ALU
// and a cycle-level reference of the scheduling rules.
module tb_alu_req_sched;

  localparam int N = 8;
  localparam int M = 4;

  typedef struct packed {
    logic         m;
    logic [M-1:0] c;
    logic         ci;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pay_t;

  typedef struct {
    logic       id;
    logic [N:0] res;
    logic [5:0] flg;
    int         due;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [1:0]   v = 2'b00;
  logic [M-1:0] cmd [2];
  logic         mode [2];
  logic         cin [2];
  logic [N-1:0] opa [2];
  logic [N-1:0] opb [2];
  logic         rdy0, rdy1;
  logic         ALU_CE, ALU_MODE, ALU_CIN;
  logic [1:0]   ALU_INP_VALID;
  logic [M-1:0] ALU_CMD;
  logic [N-1:0] ALU_OPA, ALU_OPB;
  logic [N:0]   ALU_RES;
  logic [5:0]   ALU_FLAGS;
  logic         RSP_VALID, RSP_ID;
  logic [N:0]   RSP_RES;
  logic [5:0]   RSP_FLAGS;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   next_free = 0;
  logic m_last = 1'b1;
  pay_t cur = '0;
  exp_t sbq[$];
  int   gnt_log[$];
  int   rsp_cyc[$];
  logic       last_id;
  logic [N:0] last_res;
  logic [5:0] last_flg;

  alu_req_sched dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(v[0]), .REQ0_READY(rdy0),
    .REQ0_CMD(cmd[0]), .REQ0_MODE(mode[0]),
    .REQ0_CIN(cin[0]), .REQ0_OPA(opa[0]),
    .REQ0_OPB(opb[0]),
    .REQ1_VALID(v[1]), .REQ1_READY(rdy1),
    .REQ1_CMD(cmd[1]), .REQ1_MODE(mode[1]),
    .REQ1_CIN(cin[1]), .REQ1_OPA(opa[1]),
    .REQ1_OPB(opb[1]),
    .ALU_CE(ALU_CE), .ALU_INP_VALID(ALU_INP_VALID),
    .ALU_CMD(ALU_CMD), .ALU_MODE(ALU_MODE),
    .ALU_CIN(ALU_CIN), .ALU_OPA(ALU_OPA),
    .ALU_OPB(ALU_OPB), .ALU_RES(ALU_RES),
    .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [N:0] ref_res(input pay_t p);
    int a = int'(p.a);
    int b = int'(p.b);
    int r;
    if (p.m) begin
      case (p.c)
        4'd0:    r = a + b;
        4'd1:    r = a - b;
        4'd2:    r = a + b + int'(p.ci);
        4'd9:    r = (a + 1) * (b + 1);
        4'd10:   r = (a * 2) * b;
        default: r = a;
      endcase
    end else begin
      case (p.c)
        4'd0:    r = a & b;
        4'd1:    r = a | b;
        4'd2:    r = a ^ b;
        default: r = (~a) & 255;
      endcase
    end
    return r[N:0];
  endfunction

  function automatic logic [5:0] ref_flg(input pay_t p);
    logic [5:0] f = '0;
    logic [N:0] r = ref_res(p);
    f[5] = p.m && (p.c > 4'd10);
    f[4] = p.m && (p.c == 4'd0) &&
           (p.a[7] == p.b[7]) && (r[7] != p.a[7]);
    f[3] = p.m && (p.c <= 4'd2) && r[N];
    f[2] = p.a > p.b;
    f[1] = p.a < p.b;
    f[0] = p.a == p.b;
    return f;
  endfunction

  function automatic int lat_of(input pay_t p);
    return (p.m && (p.c == 4'd9 || p.c == 4'd10)) ? 4 : 3;
  endfunction

  // behavioural ALU: answers only while the bus is enabled
  pay_t alu_p;
  always_comb begin
    alu_p     = {ALU_MODE, ALU_CMD, ALU_CIN, ALU_OPA, ALU_OPB};
    ALU_RES   = '0;
    ALU_FLAGS = '0;
    if (ALU_CE && ALU_INP_VALID == 2'b11) begin
      ALU_RES   = ref_res(alu_p);
      ALU_FLAGS = ref_flg(alu_p);
    end
  end

  // reference scheduler: grant rule, busy window, bus contents
  logic [1:0] eg;
  logic       m_idle;
  pay_t       gp;
  always @(negedge CLK) if (RST) begin
    m_idle = (cyc >= next_free);
    eg = 2'b00;
    if (m_idle) begin
      if (v == 2'b01) eg = 2'b01;
      else if (v == 2'b10) eg = 2'b10;
      else if (v == 2'b11) eg = m_last ? 2'b01 : 2'b10;
    end
    chk("ready", {62'd0, rdy1, rdy0}, {62'd0, eg});
    if (m_idle)
      chk("alu_idle", {ALU_CE, ALU_INP_VALID}, 3'b000);
    else
      chk("alu_bus",
          {ALU_CE, ALU_INP_VALID, ALU_MODE, ALU_CMD,
           ALU_CIN, ALU_OPA, ALU_OPB},
          {1'b1, 2'b11, cur});
    if (eg != 2'b00) begin
      gp = {mode[eg[1]], cmd[eg[1]], cin[eg[1]],
            opa[eg[1]], opb[eg[1]]};
      cur = gp;
      sbq.push_back('{eg[1], ref_res(gp), ref_flg(gp),
                      cyc + lat_of(gp)});
      m_last = eg[1];
      next_free = cyc + lat_of(gp);
      gnt_log.push_back(int'(eg[1]));
    end
  end

  // response monitor: pops the scoreboard on every strobe
  exp_t e;
  always @(negedge CLK) if (RST) begin
    if (RSP_VALID) begin
      last_id  = RSP_ID;
      last_res = RSP_RES;
      last_flg = RSP_FLAGS;
      rsp_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        chk("rsp_spurious", 64'(RSP_VALID), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", 64'(RSP_ID), 64'(e.id));
        chk("rsp_res", 64'(RSP_RES), 64'(e.res));
        chk("rsp_flags", 64'(RSP_FLAGS), 64'(e.flg));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("rsp_missing", 64'(RSP_VALID), 64'd1);
    end
  end

  function automatic logic rdy_of(input int id);
    return (id == 1) ? rdy1 : rdy0;
  endfunction

  task automatic drive(input int id, input pay_t p);
    v[id]    = 1'b1;
    mode[id] = p.m;
    cmd[id]  = p.c;
    cin[id]  = p.ci;
    opa[id]  = p.a;
    opb[id]  = p.b;
  endtask

  task automatic wait_acc(input int id, input bit may_drop,
                          output bit acc);
    int k = 0;
    acc = 1'b0;
    forever begin
      @(negedge CLK);
      if (v[id] && rdy_of(id)) begin
        acc = 1'b1;
        break;
      end
      if (may_drop && $urandom_range(0, 15) == 0) break;
      k++;
      if (k > 60) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  function automatic pay_t rand_pay(input int kind);
    pay_t p;
    p.m  = 1'($urandom_range(0, 1));
    p.c  = 4'($urandom_range(0, 15));
    p.ci = 1'($urandom_range(0, 1));
    p.a  = 8'($urandom_range(0, 255));
    p.b  = 8'($urandom_range(0, 255));
    if (kind == 1 && lat_of(p) == 4) p.c = 4'd0;
    if (kind == 2) begin
      p.m = 1'b1;
      p.c = 4'(9 + $urandom_range(0, 1));
    end
    return p;
  endfunction

  task automatic send(input int id, input pay_t p);
    bit acc;
    @(posedge CLK); #1;
    drive(id, p);
    wait_acc(id, 1'b0, acc);
    @(posedge CLK); #1;
    v[id] = 1'b0;
  endtask

  // valid stays high across ops; new payload after each accept
  task automatic burst(input int id, input int n,
                       input int kind);
    bit acc;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      drive(id, rand_pay(kind));
      wait_acc(id, 1'b0, acc);
    end
    @(posedge CLK); #1;
    v[id] = 1'b0;
  endtask

  task automatic rnd(input int id, input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      @(posedge CLK); #1;
      drive(id, rand_pay(0));
      wait_acc(id, 1'b1, acc);
      @(posedge CLK); #1;
      v[id] = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
  endtask

  logic [63:0] all_out;
  always_comb
    all_out = {20'd0, rdy0, rdy1, ALU_CE, ALU_INP_VALID,
               ALU_CMD, ALU_MODE, ALU_CIN, ALU_OPA,
               ALU_OPB, RSP_VALID, RSP_ID, RSP_RES,
               RSP_FLAGS};

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd[i] = '0; mode[i] = 1'b0; cin[i] = 1'b0;
      opa[i] = '0; opb[i] = '0;
    end
    #12;
    chk("reset_outputs", all_out, 64'd0);
    #11 RST = 1'b1;
    idle_cycles(2);

    send(0, '{m: 1'b1, c: 4'd0, ci: 1'b0,
              a: 8'h0F, b: 8'h01});
    idle_cycles(4);
    chk("add_res", 64'(last_res), 64'h010);
    chk("add_id", 64'(last_id), 64'd0);

    send(1, '{m: 1'b1, c: 4'd9, ci: 1'b0,
              a: 8'h03, b: 8'h04});
    idle_cycles(4);
    chk("mul_res", 64'(last_res), 64'h014);
    chk("mul_id", 64'(last_id), 64'd1);

    gnt_log.delete();
    fork
      burst(0, 3, 0);
      burst(1, 3, 0);
    join
    idle_cycles(5);
    chk("cont_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      chk("cont_order", 64'(gnt_log[i]), 64'(i % 2));

    rsp_cyc.delete();
    burst(0, 4, 1);
    idle_cycles(5);
    chk("b2b_count", 64'(rsp_cyc.size()), 64'd4);
    for (int i = 1; i < 4 && i < rsp_cyc.size(); i++)
      chk("b2b_spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]),
          64'd3);

    send(0, '{m: 1'b1, c: 4'd12, ci: 1'b0,
              a: 8'h55, b: 8'h22});
    idle_cycles(4);
    chk("err_flag", 64'(last_flg[5]), 64'd1);
    send(1, rand_pay(1));
    idle_cycles(4);

    send(0, '{m: 1'b1, c: 4'd10, ci: 1'b0,
              a: 8'h07, b: 8'h05});
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    chk("rst_wait_outputs", all_out, 64'd0);
    sbq.delete();
    m_last = 1'b1;
    next_free = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("rst_no_rsp", 64'(RSP_VALID), 64'd0);
    end
    @(posedge CLK); #3;
    RST = 1'b1;
    idle_cycles(3);
    gnt_log.delete();
    fork
      send(0, rand_pay(1));
      send(1, rand_pay(1));
    join
    idle_cycles(5);
    chk("rst_first_gnt",
        64'(gnt_log.size() > 0 ? gnt_log[0] : 9), 64'd0);

    fork
      rnd(0, 40);
      rnd(1, 40);
    join

    for (int k = 0; k < 20 && sbq.size() != 0; k++)
      @(posedge CLK);
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
